alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX pipeline stage of the pcpu. Decodes a 32-bit RV32I instruction and registers the ALU inputs.
//  Outputs: ALU_operation ({Fun7[5],Fun3}), operands ALU_A / ALU_B, rd and reg_write.
//  Producer side of the ALU interface. Uses a valid/ready handshake, stalls on downstream back-pressure,
//  and accepts a flush from branch/jump resolution.
// PARAMETERS
//  XLEN      32           datapath width; only 32 is supported
//  RESET_PC  32'h0000_0000  value held in out_pc after reset
// PORTS
//  clk            in   1   single clock; all state updates on the rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  in_valid       in   1   IF/ID presents an instruction
//  in_ready       out  1   stage can accept this cycle
//  inst           in   32  instruction word
//  pc             in   32  address of inst
//  rs1_data       in   32  register-file read of inst[19:15] (forwarded by the caller)
//  rs2_data       in   32  register-file read of inst[24:20]
//  flush          in   1   kill the held and incoming instruction
//  out_valid      out  1   registered outputs are valid
//  out_ready      in   1   EX consumes this cycle
//  ALU_A          out  32  ALU operand A
//  ALU_B          out  32  ALU operand B
//  ALU_operation  out  4   {Fun7[5],Fun3[2:0]} encoding (0000 add, 1000 sub, 0001 sll, ... 0111 and)
//  out_rd         out  5   destination register
//  out_pc         out  32  pc of the held instruction
//  reg_write      out  1   instruction writes rd (forced 0 when rd==0)
//  mem_op         out  2   00 none, 01 load, 10 store
//  illegal        out  1   held instruction is not decodable
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid, reg_write, illegal = 0; ALU_A, ALU_B = 0; ALU_operation = 0000;
//   - out_rd = 0; mem_op = 00; out_pc = RESET_PC.
//  Handshake:
//   - in_ready = !out_valid | out_ready (combinational; no other comb in->out path).
//   - Load on edge when in_valid & in_ready; latency 1 cycle inst -> outputs.
//   - Held: while out_valid & !out_ready, every output is stable.
//   - Bubble: consume without load -> out_valid=0.
//  Flush: edge with flush=1 -> out_valid=0 regardless of in_valid/out_ready; flush beats load.
//   Data regs may hold stale values.
//  Decode by opcode (inst[6:0]):
//   - 0110011 R:  A=rs1, B=rs2, op={inst[30],f3}. inst[31:25] must be 0000000, or 0100000 with f3 000/101;
//     otherwise illegal.
//   - 0010011 I:  A=rs1, B=sext(inst[31:20]).
//     op={1'b0,f3} except f3=101 -> {inst[30],101}; addi never yields 1000.
//     f3=001 needs inst[31:25]=0; f3=101 needs 0 or 0100000; B=shamt (zero-ext inst[24:20]) for shifts.
//   - 0110111 LUI: A=0, B={inst[31:12],12'b0}, op=0000.
//   - 0010111 AUIPC: A=pc, B={inst[31:12],12'b0}, op=0000.
//   - 0000011 LOAD: A=rs1, B=sext(I-imm), op=0000, mem_op=01.
//   - 0100011 STORE: A=rs1, B=sext({inst[31:25],inst[11:7]}), op=0000, mem_op=10, reg_write=0.
//   - 1101111 / 1100111 JAL/JALR: A=pc, B=4, op=0000 (link value).
//   - Anything else: illegal=1, reg_write=0, mem_op=00, op=0000, A=B=0.
//   - reg_write=1 for R, I, LUI, AUIPC, LOAD, JAL, JALR when rd!=0.
//  Simultaneous events:
//   - rst_n low overrides everything.
//   - Flush during a held stall drops the instruction.
//   - out_ready with in_valid reloads back-to-back at full throughput (no bubble).
// TESTING
//  - Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, ALU_operation=0000 immediately (async).
//  - Load 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle:
//    out_valid=1, op=0000, A=5, B=7, out_rd=3, reg_write=1.
//  - 0x402081B3 -> op=1000. 0xFFF00093 (addi x1,x0,-1) -> op=0000, B=0xFFFFFFFF.
//  - 0x4032D293 (srai x5,x5,3) -> op=1101, B=3.
//  - 0x123450B7 (lui x1,0x12345) -> A=0, B=0x12345000, reg_write=1.
//  - Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged;
//    out_ready=1 -> new inst next cycle. Flush with in_valid=1 -> out_valid=0 next cycle.
//  - Illegal: opcode 1111111 -> illegal=1, reg_write=0, mem_op=00.
//    0x02208033 (f7=0000001) -> illegal=1.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// ID->EX bus of the ALU issue stage: upstream instruction handshake plus downstream ALU operands.
// The master modport belongs to the issue stage; the slave modport belongs to whatever feeds and consumes it.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALU_A;
  logic [XLEN-1:0] ALU_B;
  logic [3:0]      ALU_operation;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_pc;
  logic            reg_write;
  logic [1:0]      mem_op;
  logic            illegal;

  modport master (
    input  in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, ALU_A, ALU_B, ALU_operation, out_rd, out_pc,
           reg_write, mem_op, illegal
  );

  modport slave (
    output in_valid, inst, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, ALU_A, ALU_B, ALU_operation, out_rd, out_pc,
           reg_write, mem_op, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX stage: decodes an RV32I instruction into ALU operands/op and holds them behind a
// valid/ready register slice with flush.
module alu_issue_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.master bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic [31:0]     w_imm_i, w_imm_s, w_imm_u, w_shamt;
  logic [XLEN-1:0] w_a, w_b;
  logic [3:0]      w_op;
  logic [1:0]      w_mem;
  logic            w_wr, w_ill, w_load;

  logic            r_valid;
  logic [XLEN-1:0] r_a, r_b, r_pc;
  logic [3:0]      r_op;
  logic [4:0]      r_rd;
  logic            r_wr, r_ill;
  logic [1:0]      r_mem;

  assign w_opc   = bus.inst[6:0];
  assign w_f3    = bus.inst[14:12];
  assign w_f7    = bus.inst[31:25];
  assign w_rd    = bus.inst[11:7];
  assign w_imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign w_imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign w_imm_u = {bus.inst[31:12], 12'b0};
  assign w_shamt = {27'b0, bus.inst[24:20]};

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_op  = 4'b0000;
    w_mem = 2'b00;
    w_wr  = 1'b0;
    w_ill = 1'b0;
    case (w_opc)
      OP_R: begin
        w_a  = bus.rs1_data;
        w_b  = bus.rs2_data;
        w_op = {bus.inst[30], w_f3};
        w_wr = 1'b1;
        // Only add/sub and srl/sra have a funct7 alternate encoding.
        w_ill = !((w_f7 == 7'b0000000) ||
                  (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OP_I: begin
        w_a  = bus.rs1_data;
        w_b  = w_imm_i;
        w_op = {1'b0, w_f3};
        w_wr = 1'b1;
        if (w_f3 == 3'b001) begin
          w_b   = w_shamt;
          w_ill = (w_f7 != 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_b   = w_shamt;
          w_op  = {bus.inst[30], 3'b101};
          w_ill = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
        end
      end
      OP_LUI: begin
        w_b  = w_imm_u;
        w_wr = 1'b1;
      end
      OP_AUIPC: begin
        w_a  = bus.pc;
        w_b  = w_imm_u;
        w_wr = 1'b1;
      end
      OP_LOAD: begin
        w_a   = bus.rs1_data;
        w_b   = w_imm_i;
        w_mem = 2'b01;
        w_wr  = 1'b1;
      end
      OP_STORE: begin
        w_a   = bus.rs1_data;
        w_b   = w_imm_s;
        w_mem = 2'b10;
      end
      OP_JAL, OP_JALR: begin
        w_a  = bus.pc;
        w_b  = 32'd4;
        w_wr = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // An undecodable instruction carries no side effects into EX.
    if (w_ill) begin
      w_a   = '0;
      w_b   = '0;
      w_op  = 4'b0000;
      w_mem = 2'b00;
      w_wr  = 1'b0;
    end
    if (w_rd == 5'd0) w_wr = 1'b0;
  end

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_load       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 4'b0000;
      r_rd    <= 5'd0;
      r_pc    <= RESET_PC;
      r_wr    <= 1'b0;
      r_mem   <= 2'b00;
      r_ill   <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_op    <= w_op;
      r_rd    <= w_rd;
      r_pc    <= bus.pc;
      r_wr    <= w_wr;
      r_mem   <= w_mem;
      r_ill   <= w_ill;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.ALU_A         = r_a;
  assign bus.ALU_B         = r_b;
  assign bus.ALU_operation = r_op;
  assign bus.out_rd        = r_rd;
  assign bus.out_pc        = r_pc;
  assign bus.reg_write     = r_wr;
  assign bus.mem_op        = r_mem;
  assign bus.illegal       = r_ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage against a one-entry reference model.
module tb_alu_issue_stage;
  localparam logic [31:0] RESET_PC = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32)) ifc ();
  alu_issue_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int total = 0;
  int passed = 0;

  logic        m_valid, m_wr, m_ill;
  logic [31:0] m_a, m_b, m_pc;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic [1:0]  m_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_ill = 0; m_a = 0; m_b = 0;
    m_pc = RESET_PC; m_op = 0; m_rd = 0; m_mem = 0;
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return 32'($signed(v));
  endfunction

  // Decode from the ISA rules: each instruction class yields its operands directly.
  task automatic ref_decode(input logic [31:0] in, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            output logic [31:0] a, output logic [31:0] b, output logic [3:0] op,
                            output logic wr, output logic [1:0] mem, output logic ill);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = in[14:12];
    f7 = in[31:25];
    a = 0; b = 0; op = 0; wr = 0; mem = 0; ill = 0;
    if (in[6:0] == 7'b0110011) begin
      a = rs1; b = rs2; op = {in[30], f3}; wr = 1;
      if (f7 == 7'h00) ill = 0;
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ill = 0;
      else ill = 1;
    end else if (in[6:0] == 7'b0010011) begin
      a = rs1; wr = 1;
      if (f3 == 3'd1) begin b = in[24:20]; op = 4'b0001; ill = (f7 != 0); end
      else if (f3 == 3'd5) begin b = in[24:20]; op = {in[30], 3'd5}; ill = !(f7 == 0 || f7 == 7'h20); end
      else begin b = sx12(in[31:20]); op = {1'b0, f3}; end
    end else if (in[6:0] == 7'b0110111) begin
      b = in & 32'hFFFF_F000; wr = 1;
    end else if (in[6:0] == 7'b0010111) begin
      a = pc; b = in & 32'hFFFF_F000; wr = 1;
    end else if (in[6:0] == 7'b0000011) begin
      a = rs1; b = sx12(in[31:20]); mem = 1; wr = 1;
    end else if (in[6:0] == 7'b0100011) begin
      a = rs1; b = sx12({in[31:25], in[11:7]}); mem = 2;
    end else if (in[6:0] == 7'b1101111 || in[6:0] == 7'b1100111) begin
      a = pc; b = 4; wr = 1;
    end else begin
      ill = 1;
    end
    if (ill) begin a = 0; b = 0; op = 0; wr = 0; mem = 0; end
    if (in[11:7] == 0) wr = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(ifc.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".A"}, ifc.ALU_A, m_a);
      chk({tag, ".B"}, ifc.ALU_B, m_b);
      chk({tag, ".op"}, 32'(ifc.ALU_operation), 32'(m_op));
      chk({tag, ".rd"}, 32'(ifc.out_rd), 32'(m_rd));
      chk({tag, ".pc"}, ifc.out_pc, m_pc);
      chk({tag, ".reg_write"}, 32'(ifc.reg_write), 32'(m_wr));
      chk({tag, ".mem_op"}, 32'(ifc.mem_op), 32'(m_mem));
      chk({tag, ".illegal"}, 32'(ifc.illegal), 32'(m_ill));
    end
  endtask

  // Drive one cycle of inputs, check in_ready, clock, update the model and check the outputs.
  task automatic step(input string tag, input logic [31:0] in, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic iv, input logic ordy, input logic fl);
    logic        accept;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        wr, ill;
    logic [1:0]  mem;
    ifc.inst = in; ifc.pc = pc; ifc.rs1_data = rs1; ifc.rs2_data = rs2;
    ifc.in_valid = iv; ifc.out_ready = ordy; ifc.flush = fl;
    #1;
    accept = !m_valid || ordy;
    chk({tag, ".in_ready"}, 32'(ifc.in_ready), 32'(accept));
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (iv && accept) begin
      ref_decode(in, pc, rs1, rs2, a, b, op, wr, mem, ill);
      m_valid = 1; m_a = a; m_b = b; m_op = op; m_wr = wr; m_mem = mem; m_ill = ill;
      m_rd = in[11:7]; m_pc = pc;
    end else if (ordy) m_valid = 0;
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opc;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: opc = 7'b0110011;
      1: opc = 7'b0010011;
      2: opc = 7'b0110111;
      3: opc = 7'b0010111;
      4: opc = 7'b0000011;
      5: opc = 7'b0100011;
      6: opc = 7'b1101111;
      7: opc = 7'b1100111;
      8: opc = 7'b0010011;
      default: opc = w[6:0];
    endcase
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    w[6:0] = opc;
    return w;
  endfunction

  initial begin
    ifc.in_valid = 0; ifc.out_ready = 0; ifc.flush = 0;
    ifc.inst = 0; ifc.pc = 0; ifc.rs1_data = 0; ifc.rs2_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(ifc.out_valid), 0);
    chk("rst.A", ifc.ALU_A, 0);
    chk("rst.B", ifc.ALU_B, 0);
    chk("rst.op", 32'(ifc.ALU_operation), 0);
    chk("rst.rd", 32'(ifc.out_rd), 0);
    chk("rst.pc", ifc.out_pc, RESET_PC);
    chk("rst.reg_write", 32'(ifc.reg_write), 0);
    chk("rst.mem_op", 32'(ifc.mem_op), 0);
    chk("rst.illegal", 32'(ifc.illegal), 0);
    rst_n = 1;

    step("add", 32'h002081B3, 32'h100, 5, 7, 1, 1, 0);
    chk("add.op_k", 32'(ifc.ALU_operation), 0);
    chk("add.A_k", ifc.ALU_A, 5);
    chk("add.B_k", ifc.ALU_B, 7);
    chk("add.rd_k", 32'(ifc.out_rd), 3);
    chk("add.wr_k", 32'(ifc.reg_write), 1);
    step("sub", 32'h402081B3, 32'h104, 9, 2, 1, 1, 0);
    chk("sub.op_k", 32'(ifc.ALU_operation), 4'b1000);
    step("addi", 32'hFFF00093, 32'h108, 0, 0, 1, 1, 0);
    chk("addi.op_k", 32'(ifc.ALU_operation), 0);
    chk("addi.B_k", ifc.ALU_B, 32'hFFFF_FFFF);
    step("srai", 32'h4032D293, 32'h10C, 32'h8000_0000, 0, 1, 1, 0);
    chk("srai.op_k", 32'(ifc.ALU_operation), 4'b1101);
    chk("srai.B_k", ifc.ALU_B, 3);
    step("lui", 32'h123450B7, 32'h110, 32'h55, 32'h66, 1, 1, 0);
    chk("lui.A_k", ifc.ALU_A, 0);
    chk("lui.B_k", ifc.ALU_B, 32'h1234_5000);
    chk("lui.wr_k", 32'(ifc.reg_write), 1);

    for (int i = 0; i < 3; i++) begin
      step("stall", 32'h00500113, 32'h114, 1, 2, 1, 0, 0);
      chk("stall.in_ready_k", 32'(ifc.in_ready), 0);
      chk("stall.B_k", ifc.ALU_B, 32'h1234_5000);
    end
    step("resume", 32'h00500113, 32'h114, 1, 2, 1, 1, 0);
    chk("resume.B_k", ifc.ALU_B, 5);
    step("flush", 32'h002081B3, 32'h118, 1, 2, 1, 0, 1);
    chk("flush.valid_k", 32'(ifc.out_valid), 0);

    step("ill_opc", 32'h0000007F, 32'h11C, 3, 4, 1, 1, 0);
    chk("ill_opc.ill_k", 32'(ifc.illegal), 1);
    chk("ill_opc.wr_k", 32'(ifc.reg_write), 0);
    chk("ill_opc.mem_k", 32'(ifc.mem_op), 0);
    step("ill_f7", 32'h02208033, 32'h120, 3, 4, 1, 1, 0);
    chk("ill_f7.ill_k", 32'(ifc.illegal), 1);
    step("store", 32'hFE20AE23, 32'h124, 32'h40, 0, 1, 1, 0);
    step("jal", 32'h008000EF, 32'h128, 0, 0, 1, 0, 0);
    step("flush_stall", 32'h002081B3, 32'h12C, 1, 2, 1, 0, 1);

    step("pre_rst", 32'h002081B3, 32'h130, 1, 2, 1, 1, 0);
    chk("pre_rst.valid_k", 32'(ifc.out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst.out_valid", 32'(ifc.out_valid), 0);
    chk("async_rst.op", 32'(ifc.ALU_operation), 0);
    chk("async_rst.pc", ifc.out_pc, RESET_PC);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 400; i++) begin
      step("rand", rand_inst(), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
